iperm_ctrl_n: RTL and testbench
===============================

Name: iperm_ctrl_n

Overview:
Parametrised successor to the 2:1 input-permute controller. It arbitrates NCH data request channels under a kernel-parameter (kp) token stream. Each valid kp token selects one input channel and forwards exactly k_len+1 beats from it to the single downstream request/acknowledge port, then releases. Invalid tokens (opcode not in VALID_MASK, or k_sel out of range) are consumed and counted without forwarding data. The block sits between the per-channel data sources and the permute datapath.

Parameters:
NCH, 2, number of upstream data channels (>=2)
SELW, $clog2(NCH), width of channel select
KW, 4, opcode width of k_ctrl
VALID_MASK, 16'h00A2, bit i set = opcode i legal (default legal set: 1, 5, 7); width 2**KW
LENW, 8, beat-length field width
ERRW, 8, error counter width

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
t_dat_req  in  NCH  per-channel data request
t_dat_ack  out  NCH  per-channel data acknowledge
t_kp_req  in  1  kp token request
t_kp_ack  out  1  kp token acknowledge (token consumed)
k_ctrl  in  KW  opcode, sampled with t_kp_req
k_sel  in  SELW  source channel, sampled with t_kp_req
k_len  in  LENW  beats minus one, sampled with t_kp_req
i_dat_req  out  1  downstream data request
i_dat_ack  in  1  downstream acknowledge
i_op  out  KW  latched opcode of the active token
i_last  out  1  high during the final beat of a token
busy  out  1  high in RUN
err_cnt  out  ERRW  saturating count of rejected tokens

Behaviour:
- Reset (async assert, sync release): state IDLE; op_q, sel_q, len_q, beat_q and err_cnt all 0. All outputs 0. A reset during RUN aborts the token: remaining beats are dropped, no acknowledge is issued, and the next token starts fresh.
- invalid = ~VALID_MASK[k_ctrl] | (k_sel >= NCH). Combinational from the kp inputs.
- State IDLE:
  - t_kp_ack = t_kp_req, in the same cycle for both valid and invalid tokens. i_dat_req = 0. All t_dat_ack = 0.
  - Valid token: latch k_ctrl->op_q, k_sel->sel_q, k_len->len_q; clear beat_q; go to RUN next cycle.
  - Invalid token: stay in IDLE; err_cnt += 1, saturating at 2**ERRW-1 (no wrap).
- State RUN:
  - t_kp_ack = 0, so a pending token waits.
  - i_dat_req = t_dat_req[sel_q].
  - t_dat_ack[sel_q] = i_dat_ack; all other t_dat_ack = 0.
  - beat = t_dat_req[sel_q] & i_dat_ack.
  - On a beat: beat_q += 1.
  - i_last = (beat_q == len_q), combinational.
  - beat with i_last: go to IDLE next cycle. This costs a mandatory one-cycle bubble before the next token is accepted.
  - No beat (source idle or downstream stall): all state holds.
- i_op = op_q, valid while busy. It holds its last value in IDLE.
- busy = (state == RUN), registered.
- Latency: kp acknowledged in cycle T; first forwarded request possible in T+1.
- Token length: k_len = 0 gives 1 beat; k_len = 2**LENW-1 gives 2**LENW beats. beat_q is LENW wide and never wraps within a token.
- Requests on non-selected channels are ignored and never acknowledged while in RUN.
- Request/acknowledge paths are combinational, matching the existing permute controllers. No skid buffer.

Decomposition:
- Package iperm_pkg:
  - state enum {IDLE, RUN}
  - default VALID_MASK constant
  - localparam helper for SELW
- No sub-module. The saturating error counter stays inline (under 10 lines).

Test Plan:
1. Reset with all inputs toggling -> every output 0, err_cnt=0. Release reset -> IDLE, busy=0.
2. k_ctrl=5, k_sel=1, k_len=3 with t_dat_req=2'b11 and i_dat_ack=1 -> t_kp_ack high for 1 cycle; then 4 beats. t_dat_ack=2'b10 each beat; ch0 ack stays 0. i_last on 4th beat; busy falls the next cycle; i_op=5 throughout.
3. k_ctrl=2 (illegal), then k_sel=3 with NCH=2 -> each acknowledged the same cycle, i_dat_req never high, err_cnt 0->1->2. Force 300 invalid tokens -> err_cnt holds 255.
4. Valid token k_len=2; i_dat_ack held low 3 cycles mid-token and t_dat_req dropped 2 cycles -> beat_q frozen during both. Exactly 3 beats total; i_last only on the 3rd.
5. Second kp token presented during RUN -> t_kp_ack stays 0 until IDLE. Acknowledged exactly one cycle after the final beat of the first token.
6. Assert reset_n low after 2 of 5 beats -> immediate IDLE, acks 0. New token k_sel=0, k_len=0 -> single beat with i_last=1.

Source files
------------

// File: rtl/iperm_pkg.sv
// Shared types and defaults for the input-permute controller family.
package iperm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Default legal opcode set: 1, 5 and 7.
  localparam logic [15:0] VALID_MASK_DEF = 16'h00A2;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iperm_ctrl_n.sv
// NCH-way input-permute controller: each legal kp token forwards k_len+1 beats
// from one selected channel to the single downstream req/ack port.
module iperm_ctrl_n
  import iperm_pkg::*;
#(
  parameter int                  NCH        = 2,
  parameter int                  SELW       = sel_width(NCH),
  parameter int                  KW         = 4,
  parameter logic [2**KW-1:0]    VALID_MASK = VALID_MASK_DEF,
  parameter int                  LENW       = 8,
  parameter int                  ERRW       = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NCH-1:0]  t_dat_req,
  output logic [NCH-1:0]  t_dat_ack,
  input  logic            t_kp_req,
  output logic            t_kp_ack,
  input  logic [KW-1:0]   k_ctrl,
  input  logic [SELW-1:0] k_sel,
  input  logic [LENW-1:0] k_len,
  output logic            i_dat_req,
  input  logic            i_dat_ack,
  output logic [KW-1:0]   i_op,
  output logic            i_last,
  output logic            busy,
  output logic [ERRW-1:0] err_cnt
);

  localparam logic [SELW:0]   NCH_W   = (SELW+1)'(NCH);
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  state_e          state_q, state_d;
  logic [KW-1:0]   op_q, op_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] beat_q, beat_d;
  logic [ERRW-1:0] err_q, err_d;

  logic            kp_bad;
  logic [NCH-1:0]  sel_oh;
  logic            beat;

  assign kp_bad = ~VALID_MASK[k_ctrl] | ({1'b0, k_sel} >= NCH_W);

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      sel_oh[c] = (sel_q == SELW'(c));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      sel_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sel_d     = sel_q;
    len_d     = len_q;
    beat_d    = beat_q;
    err_d     = err_q;
    t_kp_ack  = 1'b0;
    i_dat_req = 1'b0;
    t_dat_ack = '0;
    i_last    = 1'b0;
    beat      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Reset_n gating keeps the combinational kp ack quiet while held in reset.
        t_kp_ack = t_kp_req & reset_n;
        if (t_kp_req) begin
          if (kp_bad) begin
            if (err_q != ERR_MAX) err_d = err_q + ERRW'(1);
          end else begin
            op_d    = k_ctrl;
            sel_d   = k_sel;
            len_d   = k_len;
            beat_d  = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        i_dat_req = |(t_dat_req & sel_oh);
        t_dat_ack = sel_oh & {NCH{i_dat_ack}};
        i_last    = (beat_q == len_q);
        beat      = i_dat_req & i_dat_ack;
        if (beat) begin
          beat_d = beat_q + LENW'(1);
          if (i_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_op    = op_q;
  assign busy    = (state_q == RUN);
  assign err_cnt = err_q;

endmodule

// File: tb/tb_iperm_ctrl_n.sv
// Randomised and directed bench for iperm_ctrl_n against a token-level reference model.
module tb_iperm_ctrl_n;

  localparam int NCH  = 3;
  localparam int SELW = 2;
  localparam int KW   = 4;
  localparam int LENW = 8;
  localparam int ERRW = 8;
  localparam logic [15:0] MASK = 16'h00A2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NCH-1:0]  t_dat_req;
  logic [NCH-1:0]  t_dat_ack;
  logic            t_kp_req;
  logic            t_kp_ack;
  logic [KW-1:0]   k_ctrl;
  logic [SELW-1:0] k_sel;
  logic [LENW-1:0] k_len;
  logic            i_dat_req;
  logic            i_dat_ack;
  logic [KW-1:0]   i_op;
  logic            i_last;
  logic            busy;
  logic [ERRW-1:0] err_cnt;

  iperm_ctrl_n #(
    .NCH(NCH), .SELW(SELW), .KW(KW), .VALID_MASK(MASK), .LENW(LENW), .ERRW(ERRW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .t_dat_req(t_dat_req), .t_dat_ack(t_dat_ack),
    .t_kp_req(t_kp_req), .t_kp_ack(t_kp_ack),
    .k_ctrl(k_ctrl), .k_sel(k_sel), .k_len(k_len),
    .i_dat_req(i_dat_req), .i_dat_ack(i_dat_ack),
    .i_op(i_op), .i_last(i_last), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Token-level model: active flag, channel, beats still owed, opcode, error count.
  bit m_rst;
  bit m_act;
  int m_ch;
  int m_left;
  int m_op;
  int m_err;

  task automatic model_reset();
    m_act  = 1'b0;
    m_ch   = 0;
    m_left = 0;
    m_op   = 0;
    m_err  = 0;
  endtask

  task automatic check_outputs();
    logic [31:0] e_kp, e_req, e_ack, e_last;
    if (m_rst) begin
      e_kp = 0; e_req = 0; e_ack = 0; e_last = 0;
    end else if (!m_act) begin
      e_kp = 32'(t_kp_req); e_req = 0; e_ack = 0; e_last = 0;
    end else begin
      e_kp   = 0;
      e_req  = 32'(t_dat_req[m_ch]);
      e_ack  = i_dat_ack ? (32'd1 << m_ch) : 32'd0;
      e_last = (m_left == 1) ? 32'd1 : 32'd0;
    end
    chk("t_kp_ack",  32'(t_kp_ack),  e_kp);
    chk("i_dat_req", 32'(i_dat_req), e_req);
    chk("t_dat_ack", 32'(t_dat_ack), e_ack);
    chk("i_last",    32'(i_last),    e_last);
    chk("busy",      32'(busy),      32'(m_act));
    chk("i_op",      32'(i_op),      32'(m_op));
    chk("err_cnt",   32'(err_cnt),   32'(m_err));
  endtask

  // Inputs are set just after a rising edge; this checks mid-cycle, then advances the model.
  task automatic tick();
    bit n_act;
    int n_ch, n_left, n_op, n_err;
    #2;
    check_outputs();
    n_act = m_act; n_ch = m_ch; n_left = m_left; n_op = m_op; n_err = m_err;
    if (!m_rst) begin
      if (!m_act) begin
        if (t_kp_req) begin
          if (MASK[k_ctrl] && (int'(k_sel) < NCH)) begin
            n_act  = 1'b1;
            n_ch   = int'(k_sel);
            n_left = int'(k_len) + 1;
            n_op   = int'(k_ctrl);
          end else begin
            n_err = (m_err < 255) ? m_err + 1 : 255;
          end
        end
      end else if (t_dat_req[m_ch] && i_dat_ack) begin
        n_left = m_left - 1;
        if (n_left == 0) n_act = 1'b0;
      end
    end
    @(posedge clk);
    m_act = n_act; m_ch = n_ch; m_left = n_left; m_op = n_op; m_err = n_err;
    #1;
  endtask

  task automatic set_kp(input bit req, input int op, input int sel, input int len);
    t_kp_req = req;
    k_ctrl   = KW'(op);
    k_sel    = SELW'(sel);
    k_len    = LENW'(len);
  endtask

  task automatic rand_inputs();
    int pick;
    t_dat_req = NCH'($urandom);
    i_dat_ack = ($urandom_range(0, 3) != 0);
    t_kp_req  = ($urandom_range(0, 2) == 0);
    pick      = $urandom_range(0, 4);
    case (pick)
      0: k_ctrl = 4'd1;
      1: k_ctrl = 4'd5;
      2: k_ctrl = 4'd7;
      default: k_ctrl = KW'($urandom);
    endcase
    k_sel = SELW'($urandom);
    k_len = LENW'($urandom_range(0, 6));
  endtask

  task automatic hold_reset(input int cycles);
    reset_n = 1'b0;
    m_rst   = 1'b1;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      rand_inputs();
      tick();
    end
    reset_n = 1'b1;
    m_rst   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; m_rst = 1'b1; model_reset();
    t_dat_req = '0; i_dat_ack = 1'b0;
    set_kp(0, 0, 0, 0);
    @(posedge clk); #1;

    // Reset with inputs toggling, then release into IDLE.
    hold_reset(4);
    t_dat_req = '0; i_dat_ack = 1'b0; set_kp(0, 0, 0, 0);
    tick();

    // Opcode 5 on channel 1, four beats with both channels requesting.
    t_dat_req = 3'b011; i_dat_ack = 1'b1;
    set_kp(1, 5, 1, 3);
    tick();
    set_kp(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick();

    // Illegal opcode, then out-of-range channel, then saturating run of rejects.
    set_kp(1, 2, 0, 0); tick();
    set_kp(1, 5, 3, 0); tick();
    set_kp(0, 0, 0, 0); tick();
    set_kp(1, 2, 1, 9);
    for (int i = 0; i < 300; i++) tick();
    set_kp(0, 0, 0, 0); tick();

    // Three-beat token with downstream stall and source gaps.
    t_dat_req = 3'b100; i_dat_ack = 1'b1;
    set_kp(1, 7, 2, 2); tick();
    set_kp(0, 0, 0, 0);
    tick();
    i_dat_ack = 1'b0; tick(); tick(); tick();
    i_dat_ack = 1'b1; tick();
    t_dat_req = 3'b011; tick(); tick();
    t_dat_req = 3'b100; tick();
    tick(); tick();

    // Second token presented while the first is running.
    t_dat_req = 3'b111; i_dat_ack = 1'b1;
    set_kp(1, 1, 0, 2); tick();
    set_kp(1, 5, 2, 1);
    for (int i = 0; i < 8; i++) tick();
    set_kp(0, 0, 0, 0); tick();

    // Reset after two of five beats, then a single-beat token.
    t_dat_req = 3'b001; i_dat_ack = 1'b1;
    set_kp(1, 7, 0, 4); tick();
    set_kp(0, 0, 0, 0); tick(); tick();
    hold_reset(1);
    t_dat_req = 3'b001; i_dat_ack = 1'b1;
    set_kp(1, 1, 0, 0); tick();
    set_kp(0, 0, 0, 0); tick(); tick();

    // Maximum length token: 256 beats.
    t_dat_req = 3'b010; i_dat_ack = 1'b1;
    set_kp(1, 5, 1, 255); tick();
    set_kp(0, 0, 0, 0);
    for (int i = 0; i < 260; i++) tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
